mips_top: RTL and testbench

Single-cycle 16-bit MIPS-style processor core with on-chip instruction and data memories, an 8-entry register file and one input and one output port. It is the top level of the processor: the system supplies a clock, a reset and `in_port`, and observes program results on `out_port`. Programs are preloaded into instruction memory by the bench through the hierarchical path `datapath.inst_mem.INS_MEM`.

---
 rtl/mips_top.sv | 214 +++++++++++++++++++++
 tb/tb_mips_top.sv | 262 ++++++++++++++++++++++++++
 2 files changed

// File: rtl/mips_top.sv
// mips_top: single-cycle 16-bit MIPS-style core with on-chip instruction and
// data memories, an 8-entry register file, one input and one output port.
//   clk       in   rising-edge clock
//   rst       in   synchronous active-high reset
//   in_port   in   external data sampled by IN
//   out_port  out  registered output written by OUT
// Optional feature: define MIPS_MUL_EN to make op 1101 a 16x16 MUL (low half);
// otherwise op 1101 is a NOP and no multiplier exists.
// Instruction memory is preloaded externally through datapath.inst_mem.INS_MEM.

// Instruction ROM: combinational read, contents loaded from outside the design.
module mips_inst_mem (
  input  logic [7:0]  addr,
  output logic [15:0] instr_c
);
  reg [15:0] INS_MEM [0:255];

  assign instr_c = INS_MEM[addr];
endmodule

// Datapath: fetch, decode, register file, ALU, data memory and port logic.
module mips_datapath #(
  parameter int unsigned BUS_WIDTH     = 16,
  parameter int unsigned REGFILE_DEPTH = 8
) (
  input  logic                 clk,
  input  logic                 rst,
  input  logic [BUS_WIDTH-1:0] in_port,
  output logic [BUS_WIDTH-1:0] out_port
);
  localparam int unsigned RF_AW      = $clog2(REGFILE_DEPTH);
  localparam int unsigned MEM_AW     = 8;
  localparam int unsigned DMEM_DEPTH = 256;

  typedef enum logic [3:0] {
    OP_RTYPE = 4'h0, OP_ADDI = 4'h1, OP_ANDI = 4'h2, OP_ORI  = 4'h3,
    OP_LW    = 4'h4, OP_SW   = 4'h5, OP_BEQ  = 4'h6, OP_BNE  = 4'h7,
    OP_J     = 4'h8, OP_JAL  = 4'h9, OP_JR   = 4'hA, OP_IN   = 4'hB,
    OP_OUT   = 4'hC, OP_MUL  = 4'hD, OP_NOPE = 4'hE, OP_NOPF = 4'hF
  } op_e;

  typedef enum logic [2:0] {
    FN_ADD = 3'd0, FN_SUB = 3'd1, FN_AND = 3'd2, FN_OR  = 3'd3,
    FN_XOR = 3'd4, FN_SLT = 3'd5, FN_SLL = 3'd6, FN_SRL = 3'd7
  } funct_e;

  logic [BUS_WIDTH-1:0] pc_q, pc_d;
  logic [BUS_WIDTH-1:0] out_port_q, out_port_d;
  logic [BUS_WIDTH-1:0] rf_q   [REGFILE_DEPTH];
  logic [BUS_WIDTH-1:0] dmem_q [DMEM_DEPTH];

  logic [15:0]          instr_c;
  op_e                  op;
  funct_e               funct;
  logic [RF_AW-1:0]     rs_a, rt_a, rd_a;
  logic [5:0]           imm6;
  logic [11:0]          addr12;

  logic [BUS_WIDTH-1:0] rs_val, rt_val;
  logic [BUS_WIDTH-1:0] imm_sext, imm_zext;
  logic [BUS_WIDTH-1:0] pc_plus1, br_target, j_target;
  logic [BUS_WIDTH-1:0] alu_res, r_res, dmem_rdata;
  logic [MEM_AW-1:0]    dmem_addr;

  logic                 rf_we;
  logic [RF_AW-1:0]     rf_waddr;
  logic [BUS_WIDTH-1:0] rf_wdata;
  logic                 dmem_we;

  mips_inst_mem inst_mem (
    .addr    (pc_q[MEM_AW-1:0]),
    .instr_c (instr_c)
  );

  // Field decode
  assign op     = op_e'(instr_c[15:12]);
  assign rs_a   = instr_c[11:9];
  assign rt_a   = instr_c[8:6];
  assign rd_a   = instr_c[5:3];
  assign funct  = funct_e'(instr_c[2:0]);
  assign imm6   = instr_c[5:0];
  assign addr12 = instr_c[11:0];

  // r0 reads as zero regardless of array contents
  assign rs_val = (rs_a == '0) ? '0 : rf_q[rs_a];
  assign rt_val = (rt_a == '0) ? '0 : rf_q[rt_a];

  assign imm_sext  = {{(BUS_WIDTH-6){imm6[5]}}, imm6};
  assign imm_zext  = {{(BUS_WIDTH-6){1'b0}}, imm6};
  assign pc_plus1  = pc_q + BUS_WIDTH'(1);
  assign br_target = pc_plus1 + imm_sext;
  assign j_target  = {pc_plus1[BUS_WIDTH-1:12], addr12};

  // Shared adder: ADDI result and LW/SW effective address
  assign alu_res    = rs_val + imm_sext;
  assign dmem_addr  = alu_res[MEM_AW-1:0];
  assign dmem_rdata = dmem_q[dmem_addr];

`ifdef MIPS_MUL_EN
  logic [BUS_WIDTH-1:0] mul_res;
  assign mul_res = BUS_WIDTH'(rs_val * rt_val);
`endif

  // R-type function unit
  always_comb begin
    r_res = '0;
    case (funct)
      FN_ADD: r_res = rs_val + rt_val;
      FN_SUB: r_res = rs_val - rt_val;
      FN_AND: r_res = rs_val & rt_val;
      FN_OR:  r_res = rs_val | rt_val;
      FN_XOR: r_res = rs_val ^ rt_val;
      FN_SLT: r_res = {{(BUS_WIDTH-1){1'b0}}, ($signed(rs_val) < $signed(rt_val))};
      FN_SLL: r_res = rt_val << rs_val[3:0];
      FN_SRL: r_res = rt_val >> rs_val[3:0];
      default: r_res = '0;
    endcase
  end

  // Next PC, writeback and port control
  always_comb begin
    pc_d       = pc_plus1;
    out_port_d = out_port_q;
    rf_we      = 1'b0;
    rf_waddr   = rt_a;
    rf_wdata   = alu_res;
    dmem_we    = 1'b0;
    case (op)
      OP_RTYPE: begin
        rf_we    = 1'b1;
        rf_waddr = rd_a;
        rf_wdata = r_res;
      end
      OP_ADDI: rf_we = 1'b1;
      OP_ANDI: begin
        rf_we    = 1'b1;
        rf_wdata = rs_val & imm_zext;
      end
      OP_ORI: begin
        rf_we    = 1'b1;
        rf_wdata = rs_val | imm_zext;
      end
      OP_LW: begin
        rf_we    = 1'b1;
        rf_wdata = dmem_rdata;
      end
      OP_SW:  dmem_we = 1'b1;
      OP_BEQ: if (rs_val == rt_val) pc_d = br_target;
      OP_BNE: if (rs_val != rt_val) pc_d = br_target;
      OP_J:   pc_d = j_target;
      OP_JAL: begin
        pc_d     = j_target;
        rf_we    = 1'b1;
        rf_waddr = RF_AW'(REGFILE_DEPTH - 1);
        rf_wdata = pc_plus1;
      end
      OP_JR:  pc_d = rs_val;
      OP_IN: begin
        rf_we    = 1'b1;
        rf_wdata = in_port;
      end
      OP_OUT: out_port_d = rs_val;
`ifdef MIPS_MUL_EN
      OP_MUL: begin
        rf_we    = 1'b1;
        rf_waddr = rd_a;
        rf_wdata = mul_res;
      end
`endif
      default: ;
    endcase
  end

  // Architectural state; reset suppresses all register writes that cycle
  always_ff @(posedge clk) begin
    if (rst) begin
      pc_q       <= '0;
      out_port_q <= '0;
      for (int unsigned i = 0; i < REGFILE_DEPTH; i++) rf_q[i] <= '0;
    end else begin
      pc_q       <= pc_d;
      out_port_q <= out_port_d;
      if (rf_we && (rf_waddr != '0)) rf_q[rf_waddr] <= rf_wdata;
    end
  end

  // Data memory: not cleared by reset, write blocked while in reset
  always_ff @(posedge clk) begin
    if (!rst && dmem_we) dmem_q[dmem_addr] <= rt_val;
  end

  assign out_port = out_port_q;
endmodule

// Top level
module mips_top #(
  parameter int unsigned BUS_WIDTH     = 16,
  parameter int unsigned REGFILE_DEPTH = 8
) (
  input  logic                 clk,
  input  logic                 rst,
  input  logic [BUS_WIDTH-1:0] in_port,
  output logic [BUS_WIDTH-1:0] out_port
);
  mips_datapath #(
    .BUS_WIDTH     (BUS_WIDTH),
    .REGFILE_DEPTH (REGFILE_DEPTH)
  ) datapath (
    .clk      (clk),
    .rst      (rst),
    .in_port  (in_port),
    .out_port (out_port)
  );
endmodule

// File: tb/tb_mips_top.sv
// Testbench for mips_top: directed programs with constant expectations plus
// random programs compared cycle by cycle against an instruction-level model.
module tb_mips_top;
  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic [15:0] in_port = 16'h0;
  logic [15:0] out_port;

  int n_vec = 0;
  int n_err = 0;

  // Instruction-level model state
  logic [15:0] m_imem [256];
  logic [15:0] m_dmem [256];
  logic [15:0] m_rf   [8];
  logic [15:0] m_pc;
  logic [15:0] m_out;

  always #5 clk = ~clk;

  mips_top dut (
    .clk      (clk),
    .rst      (rst),
    .in_port  (in_port),
    .out_port (out_port)
  );

  // Execute one instruction of the architectural model
  task automatic model_step(input logic r, input logic [15:0] din);
    logic [15:0] ins, a, b, sx, zx, pc1, npc, wv;
    logic [2:0]  wi;
    logic        we;
    int          op;
    if (r) begin
      m_pc = 16'h0;
      m_out = 16'h0;
      for (int i = 0; i < 8; i++) m_rf[i] = 16'h0;
      return;
    end
    ins = m_imem[m_pc[7:0]];
    op  = int'(ins[15:12]);
    a   = m_rf[ins[11:9]];
    b   = m_rf[ins[8:6]];
    sx  = {{10{ins[5]}}, ins[5:0]};
    zx  = {10'h0, ins[5:0]};
    pc1 = m_pc + 16'd1;
    npc = pc1;
    we  = 1'b0;
    wi  = ins[8:6];
    wv  = 16'h0;
    case (op)
      0: begin
        we = 1'b1;
        wi = ins[5:3];
        case (ins[2:0])
          3'd0: wv = a + b;
          3'd1: wv = a - b;
          3'd2: wv = a & b;
          3'd3: wv = a | b;
          3'd4: wv = a ^ b;
          3'd5: wv = ($signed(a) < $signed(b)) ? 16'd1 : 16'd0;
          3'd6: wv = b << a[3:0];
          default: wv = b >> a[3:0];
        endcase
      end
      1: begin we = 1'b1; wv = a + sx; end
      2: begin we = 1'b1; wv = a & zx; end
      3: begin we = 1'b1; wv = a | zx; end
      4: begin we = 1'b1; wv = m_dmem[8'(a + sx)]; end
      5: m_dmem[8'(a + sx)] = b;
      6: if (a == b) npc = pc1 + sx;
      7: if (a != b) npc = pc1 + sx;
      8: npc = {pc1[15:12], ins[11:0]};
      9: begin npc = {pc1[15:12], ins[11:0]}; we = 1'b1; wi = 3'd7; wv = pc1; end
      10: npc = a;
      11: begin we = 1'b1; wv = din; end
      12: m_out = a;
`ifdef MIPS_MUL_EN
      13: begin we = 1'b1; wi = ins[5:3]; wv = 16'(a * b); end
`endif
      default: ;
    endcase
    if (we && wi != 3'd0) m_rf[wi] = wv;
    m_pc = npc;
  endtask

  // Drive inputs on the falling edge, advance one rising edge, settle
  task automatic step_clk(input logic r, input logic [15:0] din);
    @(negedge clk);
    rst = r;
    in_port = din;
    @(posedge clk);
    model_step(r, din);
    #1;
  endtask

  // Load program into DUT ROM and the model; unused words are NOPs
  task automatic load_prog(input logic [15:0] p[$]);
    for (int i = 0; i < 256; i++) begin
      dut.datapath.inst_mem.INS_MEM[i] = (i < p.size()) ? p[i] : 16'hE000;
      m_imem[i] = (i < p.size()) ? p[i] : 16'hE000;
    end
  endtask

  function automatic logic [15:0] rand_ins();
    logic [2:0]  rt;
    int unsigned k;
    k  = $urandom_range(0, 19);
    rt = 3'($urandom);
    // Loads and stores confined to words 0..7, which the prologue initialises
    if (k == 4) return {4'h4, 3'd0, rt, 3'd0, 3'($urandom)};
    if (k == 5) return {4'h5, 3'd0, rt, 3'd0, 3'($urandom)};
    if (k >= 16) return {4'hC, 12'($urandom)};
    return {4'(k), 12'($urandom)};
  endfunction

  task automatic test_reset();
    load_prog('{16'h1045, 16'hC200});
    for (int i = 0; i < 3; i++) begin
      step_clk(1'b1, 16'($urandom));
      n_vec++;
      if (out_port !== 16'h0) begin n_err++; $display("FAIL reset_out: got %h want 0000", out_port); end
      n_vec++;
      if (dut.datapath.pc_q !== 16'h0) begin n_err++; $display("FAIL reset_pc: got %h want 0000", dut.datapath.pc_q); end
    end
    step_clk(1'b0, 16'h0);
    n_vec++;
    if (out_port !== 16'h0) begin n_err++; $display("FAIL addi_edge1: got %h want 0000", out_port); end
    for (int i = 0; i < 5; i++) begin
      step_clk(1'b0, 16'($urandom));
      n_vec++;
      if (out_port !== 16'h5) begin n_err++; $display("FAIL out5_hold%0d: got %h want 0005", i, out_port); end
    end
  endtask

  task automatic test_in_out();
    load_prog('{16'hB080, 16'hC400});
    step_clk(1'b1, 16'h0);
    step_clk(1'b0, 16'd42);
    n_vec++;
    if (out_port !== 16'h0) begin n_err++; $display("FAIL in_edge: got %h want 0000", out_port); end
    step_clk(1'b0, 16'd99);
    n_vec++;
    if (out_port !== 16'd42) begin n_err++; $display("FAIL in_out: got %h want 002a", out_port); end
    for (int i = 0; i < 3; i++) begin
      step_clk(1'b0, 16'($urandom));
      n_vec++;
      if (out_port !== 16'd42) begin n_err++; $display("FAIL in_hold%0d: got %h want 002a", i, out_port); end
    end
  endtask

  task automatic test_mem();
    load_prog('{16'h107F, 16'h5043, 16'h40C3, 16'hC600});
    step_clk(1'b1, 16'h0);
    for (int i = 0; i < 3; i++) step_clk(1'b0, 16'h0);
    n_vec++;
    if (out_port !== 16'h0) begin n_err++; $display("FAIL mem_pre: got %h want 0000", out_port); end
    step_clk(1'b0, 16'h0);
    n_vec++;
    if (out_port !== 16'hFFFF) begin n_err++; $display("FAIL sw_lw: got %h want ffff", out_port); end
  endtask

  task automatic test_branch();
    load_prog('{16'h1045, 16'h6001, 16'hC200, 16'h0260, 16'hC800});
    step_clk(1'b1, 16'h0);
    for (int i = 0; i < 3; i++) begin
      step_clk(1'b0, 16'h0);
      n_vec++;
      if (out_port !== 16'h0) begin n_err++; $display("FAIL beq_skip%0d: got %h want 0000", i, out_port); end
    end
    step_clk(1'b0, 16'h0);
    n_vec++;
    if (out_port !== 16'd10) begin n_err++; $display("FAIL beq_add: got %h want 000a", out_port); end
  endtask

  task automatic test_r0();
    load_prog('{16'h1045, 16'hC200, 16'h1007, 16'hC000});
    step_clk(1'b1, 16'h0);
    step_clk(1'b0, 16'h0);
    step_clk(1'b0, 16'h0);
    n_vec++;
    if (out_port !== 16'h5) begin n_err++; $display("FAIL r0_pre: got %h want 0005", out_port); end
    step_clk(1'b0, 16'h0);
    step_clk(1'b0, 16'h0);
    n_vec++;
    if (out_port !== 16'h0) begin n_err++; $display("FAIL r0_zero: got %h want 0000", out_port); end
  endtask

  task automatic test_jal();
    load_prog('{16'h9003, 16'hE000, 16'hE000, 16'hCE00});
    step_clk(1'b1, 16'h0);
    step_clk(1'b0, 16'h0);
    n_vec++;
    if (dut.datapath.pc_q !== 16'h3) begin n_err++; $display("FAIL jal_pc: got %h want 0003", dut.datapath.pc_q); end
    step_clk(1'b0, 16'h0);
    n_vec++;
    if (out_port !== 16'h1) begin n_err++; $display("FAIL jal_link: got %h want 0001", out_port); end
  endtask

  task automatic test_mid_reset();
    load_prog('{16'h1245, 16'hC200});
    step_clk(1'b1, 16'h0);
    for (int i = 0; i < 3; i++) step_clk(1'b0, 16'h0);
    n_vec++;
    if (out_port !== 16'h5) begin n_err++; $display("FAIL mid_pre: got %h want 0005", out_port); end
    step_clk(1'b1, 16'h0);
    n_vec++;
    if (out_port !== 16'h0) begin n_err++; $display("FAIL mid_out: got %h want 0000", out_port); end
    n_vec++;
    if (dut.datapath.pc_q !== 16'h0) begin n_err++; $display("FAIL mid_pc: got %h want 0000", dut.datapath.pc_q); end
    step_clk(1'b0, 16'h0);
    step_clk(1'b0, 16'h0);
    n_vec++;
    if (out_port !== 16'h5) begin n_err++; $display("FAIL mid_restart: got %h want 0005", out_port); end
    n_vec++;
    if (dut.datapath.pc_q !== 16'h2) begin n_err++; $display("FAIL mid_pc2: got %h want 0002", dut.datapath.pc_q); end
  endtask

  task automatic test_random();
    logic [15:0] p[$];
    for (int prog = 0; prog < 6; prog++) begin
      p.delete();
      for (int i = 0; i < 8; i++) p.push_back(16'h5000 | 16'(i));
      for (int i = 8; i < 256; i++) p.push_back(rand_ins());
      load_prog(p);
      step_clk(1'b1, 16'h0);
      for (int c = 0; c < 400; c++) begin
        step_clk(1'b0, 16'($urandom));
        n_vec++;
        if (out_port !== m_out) begin
          n_err++;
          $display("FAIL rand%0d_c%0d_out: got %h want %h", prog, c, out_port, m_out);
        end
        n_vec++;
        if (dut.datapath.pc_q !== m_pc) begin
          n_err++;
          $display("FAIL rand%0d_c%0d_pc: got %h want %h", prog, c, dut.datapath.pc_q, m_pc);
        end
        for (int r = 1; r < 8; r++) begin
          n_vec++;
          if (dut.datapath.rf_q[r] !== m_rf[r]) begin
            n_err++;
            $display("FAIL rand%0d_c%0d_r%0d: got %h want %h", prog, c, r, dut.datapath.rf_q[r], m_rf[r]);
          end
        end
      end
    end
  endtask

  initial begin
    test_reset();
    test_in_out();
    test_mem();
    test_branch();
    test_r0();
    test_jal();
    test_mid_reset();
    test_random();
    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end
endmodule
